// File: rtl/nes_pad_reader.sv
// NES controller reader: latches the pad, clocks out 8 serial bits and
// presents them as an active-high button vector, single-shot or free-running.
module nes_pad_reader #(
   parameter int CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       auto_en,
   input  logic       NES_data,
   output logic       NES_latch,
   output logic       NES_clk,
   output logic       busy,
   output logic       done,
   output logic [7:0] buttons
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LATCH  = 2'd1,
      CLK_LO = 2'd2,
      CLK_HI = 2'd3
   } state_t;

   localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
   localparam logic [8:0] LATCH_LAST = 9'(2 * CLK_DIV - 1);

   state_t     state_r, state_nx_s;
   logic [8:0] phase_r, phase_nx_s;
   logic [2:0] index_r, index_nx_s;
   logic [7:0] shift_r, shift_nx_s;
   logic [7:0] buttons_nx_s;
   logic       done_nx_s;
   logic [1:0] sync_r;
   logic       data_sync_s;

   assign data_sync_s = sync_r[1];

   // Two-flop synchronizer for the asynchronous pad data line
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], NES_data};
      end
   end

   // Next-state, bit capture and result hand-off
   always_comb begin
      state_nx_s   = state_r;
      phase_nx_s   = phase_r + 9'd1;
      index_nx_s   = index_r;
      shift_nx_s   = shift_r;
      buttons_nx_s = buttons;
      done_nx_s    = 1'b0;
      case (state_r)
         IDLE: begin
            phase_nx_s = 9'd0;
            if (start | auto_en) begin
               state_nx_s = LATCH;
               index_nx_s = 3'd0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LATCH: begin
            if (phase_r == LATCH_LAST) begin
               state_nx_s = CLK_LO;
               phase_nx_s = 9'd0;
               index_nx_s = 3'd0;
            end else begin
               state_nx_s = LATCH;
            end
         end
         CLK_LO: begin
            // Sample at the end of the low half, long after the pad's last shift settled
            if (phase_r == HALF_LAST) begin
               shift_nx_s[index_r] = ~data_sync_s;
               state_nx_s          = CLK_HI;
               phase_nx_s          = 9'd0;
            end else begin
               state_nx_s = CLK_LO;
            end
         end
         CLK_HI: begin
            if (phase_r == HALF_LAST) begin
               phase_nx_s = 9'd0;
               if (index_r < 3'd7) begin
                  index_nx_s = index_r + 3'd1;
                  state_nx_s = CLK_LO;
               end else begin
                  state_nx_s   = IDLE;
                  buttons_nx_s = shift_r;
                  done_nx_s    = 1'b1;
               end
            end else begin
               state_nx_s = CLK_HI;
            end
         end
         default: begin
            state_nx_s = IDLE;
            phase_nx_s = 9'd0;
            index_nx_s = 3'd0;
         end
      endcase
   end

   // State register and registered outputs, decoded from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         phase_r   <= 9'd0;
         index_r   <= 3'd0;
         shift_r   <= 8'h00;
         buttons   <= 8'h00;
         done      <= 1'b0;
         busy      <= 1'b0;
         NES_latch <= 1'b0;
         NES_clk   <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         phase_r   <= phase_nx_s;
         index_r   <= index_nx_s;
         shift_r   <= shift_nx_s;
         buttons   <= buttons_nx_s;
         done      <= done_nx_s;
         busy      <= (state_nx_s != IDLE);
         NES_latch <= (state_nx_s == LATCH);
         NES_clk   <= (state_nx_s == CLK_HI);
      end
   end

endmodule
